cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_if.sv | 33 +++
 rtl/cdb_arbiter.sv | 132 +++++++++++++
 tb/tb_cdb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// FU-result / CDB bundle for cdb_arbiter: per-channel valid/ready/payload in, one broadcast out.
// master = FU side (drives results and flush), slave = arbiter side.
interface cdb_arbiter_if #(
    parameter int unsigned NCH = 5,
    parameter int unsigned DW  = 32,
    parameter int unsigned TW  = 8,
    parameter int unsigned PCW = 32
);
    localparam int unsigned OW = $clog2(NCH + 1);

    logic                 flush;
    logic [NCH-1:0]       fu_valid;
    logic [NCH-1:0]       fu_ready;
    logic [NCH*DW-1:0]    fu_data;
    logic [NCH*TW-1:0]    fu_tag;
    logic [NCH*PCW-1:0]   fu_pc;
    logic                 cdb_valid;
    logic [DW-1:0]        cdb_data;
    logic [TW-1:0]        cdb_tag;
    logic [PCW-1:0]       cdb_pc;
    logic [NCH-1:0]       cdb_grant;
    logic [OW-1:0]        occupancy;

    modport master (
        output flush, fu_valid, fu_data, fu_tag, fu_pc,
        input  fu_ready, cdb_valid, cdb_data, cdb_tag, cdb_pc, cdb_grant, occupancy
    );

    modport slave (
        input  flush, fu_valid, fu_data, fu_tag, fu_pc,
        output fu_ready, cdb_valid, cdb_data, cdb_tag, cdb_pc, cdb_grant, occupancy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per FU channel, one grant per cycle onto the CDB.
// Round-robin by default; define CDB_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module cdb_arbiter #(
    parameter int unsigned NCH = 5,
    parameter int unsigned DW  = 32,
    parameter int unsigned TW  = 8,
    parameter int unsigned PCW = 32
) (
    input logic          debug_clk,
    input logic          rst,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned OW = $clog2(NCH + 1);
    localparam int unsigned IW = $clog2(NCH);

    logic [NCH-1:0] full_q, full_d;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] capture;
    logic [DW-1:0]  data_q [NCH];
    logic [TW-1:0]  tag_q  [NCH];
    logic [PCW-1:0] pc_q   [NCH];
    logic [OW-1:0]  occ_q, occ_d;
    logic [IW-1:0]  win_idx;
    logic           any_full;

    assign any_full = |full_q;

`ifdef CDB_ARB_FIXED_PRIO_EN
    always_comb begin
        win_idx = '0;
        // Descending scan so the lowest full index is the last one written.
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (full_q[i]) win_idx = IW'(i);
        end
    end
`else
    logic [IW-1:0] ptr_q;
    logic          found;
    int            idx;

    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // Scan ptr+1, ptr+2, ... wrapping at NCH; first full slot wins.
        for (int off = 1; off <= int'(NCH); off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= int'(NCH)) idx = idx - int'(NCH);
            if (!found && full_q[idx]) begin
                found   = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    always_ff @(posedge debug_clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IW'(NCH - 1);
        end else if (any_full && !bus.flush) begin
            ptr_q <= win_idx;
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (any_full) grant[win_idx] = 1'b1;
    end

    assign bus.fu_ready  = ~full_q | grant;
    assign bus.cdb_valid = any_full;
    assign bus.cdb_grant = grant;
    assign bus.occupancy = occ_q;
    assign capture       = bus.fu_valid & bus.fu_ready & {NCH{~bus.flush}};

    always_comb begin
        bus.cdb_data = '0;
        bus.cdb_tag  = '0;
        bus.cdb_pc   = '0;
        if (any_full) begin
            bus.cdb_data = data_q[win_idx];
            bus.cdb_tag  = tag_q[win_idx];
            bus.cdb_pc   = pc_q[win_idx];
        end
    end

    always_comb begin
        full_d = full_q;
        for (int i = 0; i < int'(NCH); i++) begin
            if (bus.flush) begin
                full_d[i] = 1'b0;
            end else if (capture[i]) begin
                // Tag 0 has no consumer: accept the handshake but leave the slot empty.
                full_d[i] = |bus.fu_tag[i*TW +: TW];
            end else if (grant[i]) begin
                full_d[i] = 1'b0;
            end
        end
        occ_d = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            occ_d = occ_d + OW'(full_d[i]);
        end
    end

    always_ff @(posedge debug_clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            occ_q  <= '0;
        end else begin
            full_q <= full_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge debug_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NCH); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (capture[i] && (|bus.fu_tag[i*TW +: TW])) begin
                    data_q[i] <= bus.fu_data[i*DW +: DW];
                    tag_q[i]  <= bus.fu_tag[i*TW +: TW];
                    pc_q[i]   <= bus.fu_pc[i*PCW +: PCW];
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a slot/queue-level reference model.
module tb_cdb_arbiter;
    localparam int unsigned NCH = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned TW  = 8;
    localparam int unsigned PCW = 32;
    localparam int          N   = int'(NCH);

    logic debug_clk = 1'b0;
    logic rst       = 1'b1;

    cdb_arbiter_if #(.NCH(NCH), .DW(DW), .TW(TW), .PCW(PCW)) bus ();

    cdb_arbiter #(.NCH(NCH), .DW(DW), .TW(TW), .PCW(PCW)) dut (
        .debug_clk (debug_clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 debug_clk = ~debug_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which slots hold a result, and what they hold.
    bit             m_full [NCH];
    logic [DW-1:0]  m_data [NCH];
    logic [TW-1:0]  m_tag  [NCH];
    logic [PCW-1:0] m_pc   [NCH];
`ifndef CDB_ARB_FIXED_PRIO_EN
    int             m_ptr;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_win();
`ifdef CDB_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (m_full[i]) return i;
`else
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (m_full[j]) return j;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
            m_tag[i]  = '0;
            m_pc[i]   = '0;
        end
`ifndef CDB_ARB_FIXED_PRIO_EN
        m_ptr = N - 1;
`endif
    endtask

    task automatic model_compare();
        int             w;
        int             cnt;
        logic [NCH-1:0] e_ready, e_grant;
        w       = m_win();
        cnt     = 0;
        e_grant = '0;
        for (int i = 0; i < N; i++) begin
            e_ready[i] = !m_full[i] || (w == i);
            if (m_full[i]) cnt++;
        end
        if (w >= 0) e_grant[w] = 1'b1;
        chk("fu_ready", 64'(bus.fu_ready), 64'(e_ready));
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(w >= 0));
        chk("cdb_grant", 64'(bus.cdb_grant), 64'(e_grant));
        chk("cdb_data", 64'(bus.cdb_data), (w >= 0) ? 64'(m_data[w]) : 64'd0);
        chk("cdb_tag", 64'(bus.cdb_tag), (w >= 0) ? 64'(m_tag[w]) : 64'd0);
        chk("cdb_pc", 64'(bus.cdb_pc), (w >= 0) ? 64'(m_pc[w]) : 64'd0);
        chk("occupancy", 64'(bus.occupancy), 64'(cnt));
    endtask

    task automatic model_edge();
        int w;
        bit rdy [NCH];
        w = m_win();
        for (int i = 0; i < N; i++) rdy[i] = !m_full[i] || (w == i);
        if (bus.flush) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w == i) m_full[i] = 1'b0;
                if (bus.fu_valid[i] && rdy[i] && bus.fu_tag[i*TW +: TW] != '0) begin
                    m_full[i] = 1'b1;
                    m_data[i] = bus.fu_data[i*DW +: DW];
                    m_tag[i]  = bus.fu_tag[i*TW +: TW];
                    m_pc[i]   = bus.fu_pc[i*PCW +: PCW];
                end
            end
`ifndef CDB_ARB_FIXED_PRIO_EN
            if (w >= 0) m_ptr = w;
`endif
        end
    endtask

    task automatic half();
        @(negedge debug_clk);
        model_compare();
    endtask

    task automatic clk_edge();
        @(posedge debug_clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush    = 1'b0;
        bus.fu_valid = '0;
        bus.fu_data  = '0;
        bus.fu_tag   = '0;
        bus.fu_pc    = '0;
    endtask

    task automatic drive(input int ch, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        bus.fu_valid[ch]          = 1'b1;
        bus.fu_tag[ch*TW +: TW]   = tag;
        bus.fu_data[ch*DW +: DW]  = data;
        bus.fu_pc[ch*PCW +: PCW]  = 32'h1000_0000 + 32'(tag) * 4;
    endtask

    // Called just after a rising edge; outputs must drop without waiting for a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_cdb_tag", 64'(bus.cdb_tag), 64'd0);
        chk("rst_grant", 64'(bus.cdb_grant), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_fu_ready", 64'(bus.fu_ready), 64'h1f);
        clear_inputs();
        @(posedge debug_clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int first_grant;
        int t6_len;
        clear_inputs();
        model_reset();
        do_reset();

        // Single result on ch2.
        drive(2, 8'h05, 32'h1234);
        half();
        chk("t1_ready2", 64'(bus.fu_ready[2]), 64'd1);
        clk_edge();
        clear_inputs();
        half();
        chk("t1_valid", 64'(bus.cdb_valid), 64'd1);
        chk("t1_tag", 64'(bus.cdb_tag), 64'h05);
        chk("t1_data", 64'(bus.cdb_data), 64'h1234);
        chk("t1_grant", 64'(bus.cdb_grant), 64'b00100);
        clk_edge();
        half();
        chk("t1_idle", 64'(bus.cdb_valid), 64'd0);
        clk_edge();

        // Tag 0 is accepted but never stored.
        drive(1, 8'h00, 32'hdead);
        half();
        clk_edge();
        clear_inputs();
        half();
        chk("tag0_valid", 64'(bus.cdb_valid), 64'd0);
        chk("tag0_occ", 64'(bus.occupancy), 64'd0);
        clk_edge();

        // All channels at once from reset: broadcast order follows channel index.
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 8'(i + 1), 32'hA000 + 32'(i));
        half();
        clk_edge();
        clear_inputs();
        for (int k = 1; k <= N; k++) begin
            half();
            chk("t2_tag", 64'(bus.cdb_tag), 64'(k));
            chk("t2_occ", 64'(bus.occupancy), 64'(6 - k));
            clk_edge();
        end
        half();
        chk("t2_occ_end", 64'(bus.occupancy), 64'd0);
        clk_edge();

        // Back-to-back on ch0: refill during drain, no bubble.
        drive(0, 8'h07, 32'h70);
        half();
        clk_edge();
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            if (k < 2) drive(0, 8'(8 + k), 32'h80 + 32'(k));
            half();
            chk("t3_ready0", 64'(bus.fu_ready[0]), 64'd1);
            chk("t3_tag", 64'(bus.cdb_tag), 64'(7 + k));
            clk_edge();
        end
        clear_inputs();
        half();
        chk("t3_idle", 64'(bus.cdb_valid), 64'd0);
        clk_edge();

        // Backpressure on ch1 while ch0 holds the bus.
        do_reset();
        drive(0, 8'h11, 32'h11);
        drive(1, 8'h12, 32'h12);
        half();
        clk_edge();
        clear_inputs();
        drive(1, 8'h13, 32'h13);
        half();
        chk("t4_ready1_low", 64'(bus.fu_ready[1]), 64'd0);
        chk("t4_grant0", 64'(bus.cdb_grant), 64'b00001);
        clk_edge();
        half();
        chk("t4_grant1", 64'(bus.cdb_grant), 64'b00010);
        chk("t4_tag12", 64'(bus.cdb_tag), 64'h12);
        chk("t4_ready1_high", 64'(bus.fu_ready[1]), 64'd1);
        clk_edge();
        clear_inputs();
        half();
        chk("t4_tag13", 64'(bus.cdb_tag), 64'h13);
        clk_edge();
        half();
        clk_edge();

        // Flush beats a simultaneous capture.
        drive(0, 8'h21, 32'h21);
        drive(2, 8'h22, 32'h22);
        drive(3, 8'h23, 32'h23);
        half();
        clk_edge();
        clear_inputs();
        bus.flush = 1'b1;
        drive(4, 8'h24, 32'h24);
        half();
        chk("t5_visible", 64'(bus.cdb_valid), 64'd1);
        chk("t5_occ3", 64'(bus.occupancy), 64'd3);
        clk_edge();
        clear_inputs();
        half();
        chk("t5_occ0", 64'(bus.occupancy), 64'd0);
        chk("t5_idle", 64'(bus.cdb_valid), 64'd0);
        clk_edge();

        // ch0 streams continuously while ch3 waits.
        do_reset();
        drive(0, 8'h40, 32'h40);
        drive(3, 8'h31, 32'h31);
        half();
        clk_edge();
        first_grant = -1;
        t6_len = 6;
        for (int k = 0; k < t6_len; k++) begin
            clear_inputs();
            drive(0, 8'(8'h41 + k), 32'h41 + 32'(k));
            half();
            if (bus.cdb_grant[3] && first_grant < 0) first_grant = k;
            clk_edge();
        end
`ifdef CDB_ARB_FIXED_PRIO_EN
        chk("t6_ch3_starved", 64'(first_grant), 64'(-1));
`else
        chk("t6_ch3_first_grant", 64'(first_grant), 64'd1);
`endif
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            half();
            clk_edge();
        end

        // Randomized traffic with occasional flush and asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            clear_inputs();
            bus.flush = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.fu_valid[i]          = 1'b1;
                    bus.fu_tag[i*TW +: TW]   = ($urandom_range(0, 7) == 0) ? 8'h00
                                                : 8'($urandom_range(1, 255));
                    bus.fu_data[i*DW +: DW]  = $urandom;
                    bus.fu_pc[i*PCW +: PCW]  = $urandom;
                end
            end
            half();
            clk_edge();
        end
        clear_inputs();
        half();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
